// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the 8-bit processor sequencer: opcodes, ALU selects,
// FSM states, instruction field positions and the decoded control bundle.
package cpu_ctrl_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned FIELD_W  = 8;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned ALUOP_W  = 3;

  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_LOADI = 8'h00;
  localparam logic [FIELD_W-1:0] OP_MOV   = 8'h01;
  localparam logic [FIELD_W-1:0] OP_ADD   = 8'h02;
  localparam logic [FIELD_W-1:0] OP_SUB   = 8'h03;
  localparam logic [FIELD_W-1:0] OP_AND   = 8'h04;
  localparam logic [FIELD_W-1:0] OP_OR    = 8'h05;
  localparam logic [FIELD_W-1:0] OP_J     = 8'h06;
  localparam logic [FIELD_W-1:0] OP_BEQ   = 8'h07;

  localparam logic [ALUOP_W-1:0] ALU_FWD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_TRAP      = 3'd4
  } state_e;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               sub;
    logic               imm;
    logic               writes;
    logic               is_jump;
    logic               is_branch;
    logic               illegal;
  } ctrl_t;

  // Reset/default control word: the mov encoding with no side effects.
  localparam ctrl_t CTRL_IDLE = '{aluop: ALU_FWD, default: 1'b0};

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder producing the control bundle for one instruction.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [FIELD_W-1:0] i_opcode,
  output ctrl_t              o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_opcode)
      OP_LOADI: begin o_ctrl.imm = 1'b1; o_ctrl.writes = 1'b1; end
      OP_MOV:   o_ctrl.writes = 1'b1;
      OP_ADD:   begin o_ctrl.aluop = ALU_ADD; o_ctrl.writes = 1'b1; end
      OP_SUB:   begin o_ctrl.aluop = ALU_ADD; o_ctrl.sub = 1'b1; o_ctrl.writes = 1'b1; end
      OP_AND:   begin o_ctrl.aluop = ALU_AND; o_ctrl.writes = 1'b1; end
      OP_OR:    begin o_ctrl.aluop = ALU_OR;  o_ctrl.writes = 1'b1; end
      OP_J:     o_ctrl.is_jump = 1'b1;
      OP_BEQ:   begin o_ctrl.aluop = ALU_ADD; o_ctrl.sub = 1'b1; o_ctrl.is_branch = 1'b1; end
      default:  o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller for the 8-bit datapath,
// with a fetch-timeout and illegal-opcode trap that only reset can leave.
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned         PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned         MAX_WAIT = 15
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic                 INSTR_READ,
  output logic [PC_WIDTH-1:0]  INSTR_ADDR,
  input  logic [INSTR_W-1:0]   INSTR_IN,
  input  logic                 INSTR_BUSYWAIT,
  input  logic                 ZERO,
  output logic [ALUOP_W-1:0]   ALUOP,
  output logic                 SUBMUXSEL,
  output logic                 IMMUXSEL,
  output logic [FIELD_W-1:0]   IMMEDIATE,
  output logic [REG_W-1:0]     READREG1,
  output logic [REG_W-1:0]     READREG2,
  output logic [REG_W-1:0]     WRITEREG,
  output logic                 WRITEENABLE,
  output logic                 INSTR_DONE,
  output logic                 FAULT
);

  localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_e               r_state, w_next_state;
  logic [INSTR_W-1:0]   r_ir;
  logic [WAIT_W-1:0]    r_wait, w_wait_next, w_wait_inc;
  ctrl_t                r_ctrl, w_dec;
  logic [PC_WIDTH-1:0]  r_pc, w_pc_inc, w_pc_tgt, w_offset;
  logic [FIELD_W-1:0]   r_imm;
  logic [REG_W-1:0]     r_rr1, r_rr2, r_wr;
  logic                 r_we, r_done, r_fault, r_taken;
  logic                 w_ld_ir, w_ld_ctrl, w_we_next, w_done_next;
  logic                 w_pc_upd, w_sample_zero, w_fault_next;
  logic                 w_unused;

  instr_decode u_decode (
    .i_opcode (r_ir[OPC_LSB +: FIELD_W]),
    .o_ctrl   (w_dec)
  );

  // Jump/branch target: PC+4 plus the sign-extended word offset in the dst field.
  assign w_pc_inc   = r_pc + PC_WIDTH'(4);
  assign w_offset   = {{(PC_WIDTH-FIELD_W-2){r_ir[DST_LSB+FIELD_W-1]}}, r_ir[DST_LSB +: FIELD_W], 2'b00};
  assign w_pc_tgt   = w_pc_inc + w_offset;
  assign w_wait_inc = r_wait + WAIT_W'(1);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_wait_next   = r_wait;
    w_ld_ir       = 1'b0;
    w_ld_ctrl     = 1'b0;
    w_we_next     = 1'b0;
    w_done_next   = 1'b0;
    w_pc_upd      = 1'b0;
    w_sample_zero = 1'b0;
    w_fault_next  = r_fault;
    case (r_state)
      ST_FETCH: begin
        if (!INSTR_BUSYWAIT) begin
          w_ld_ir      = 1'b1;
          w_next_state = ST_DECODE;
        end else if (w_wait_inc == WAIT_W'(MAX_WAIT)) begin
          w_fault_next = 1'b1;
          w_next_state = ST_TRAP;
        end else begin
          w_wait_next  = w_wait_inc;
        end
      end
      ST_DECODE: begin
        if (w_dec.illegal) begin
          w_fault_next = 1'b1;
          w_next_state = ST_TRAP;
        end else begin
          w_ld_ctrl    = 1'b1;
          w_next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        w_sample_zero = 1'b1;
        w_we_next     = r_ctrl.writes;
        w_done_next   = 1'b1;
        w_next_state  = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        w_pc_upd     = 1'b1;
        w_wait_next  = '0;
        w_next_state = ST_FETCH;
      end
      ST_TRAP:  w_next_state = ST_TRAP;
      default:  w_next_state = ST_TRAP;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ir    <= '0;
      r_wait  <= '0;
      r_ctrl  <= CTRL_IDLE;
      r_imm   <= '0;
      r_rr1   <= '0;
      r_rr2   <= '0;
      r_wr    <= '0;
      r_taken <= 1'b0;
      r_pc    <= RESET_PC;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (w_ld_ir) r_ir <= INSTR_IN;
      r_wait <= w_wait_next;
      if (w_ld_ctrl) begin
        r_ctrl <= w_dec;
        r_imm  <= r_ir[SRC2_LSB +: FIELD_W];
        r_rr1  <= r_ir[SRC1_LSB +: REG_W];
        r_rr2  <= r_ir[SRC2_LSB +: REG_W];
        r_wr   <= r_ir[DST_LSB +: REG_W];
      end
      if (w_sample_zero) r_taken <= r_ctrl.is_branch & ZERO;
      if (w_pc_upd) r_pc <= (r_ctrl.is_jump | r_taken) ? w_pc_tgt : w_pc_inc;
      r_we    <= w_we_next;
      r_done  <= w_done_next;
      r_fault <= w_fault_next;
    end
  end

  assign INSTR_READ  = (r_state == ST_FETCH);
  assign INSTR_ADDR  = r_pc;
  assign ALUOP       = r_ctrl.aluop;
  assign SUBMUXSEL   = r_ctrl.sub;
  assign IMMUXSEL    = r_ctrl.imm;
  assign IMMEDIATE   = r_imm;
  assign READREG1    = r_rr1;
  assign READREG2    = r_rr2;
  assign WRITEREG    = r_wr;
  assign WRITEENABLE = r_we;
  assign INSTR_DONE  = r_done;
  assign FAULT       = r_fault;

  assign w_unused = ^{r_ir[15:11], r_ctrl.illegal};

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer: hand-computed control,
// PC, handshake, trap and reset expectations.
module tb_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        INSTR_READ;
  logic [31:0] INSTR_ADDR;
  logic [31:0] INSTR_IN;
  logic        INSTR_BUSYWAIT;
  logic        ZERO;
  logic [2:0]  ALUOP;
  logic        SUBMUXSEL;
  logic        IMMUXSEL;
  logic [7:0]  IMMEDIATE;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [2:0]  WRITEREG;
  logic        WRITEENABLE;
  logic        INSTR_DONE;
  logic        FAULT;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  instr_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .MAX_WAIT(15)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .INSTR_READ     (INSTR_READ),
    .INSTR_ADDR     (INSTR_ADDR),
    .INSTR_IN       (INSTR_IN),
    .INSTR_BUSYWAIT (INSTR_BUSYWAIT),
    .ZERO           (ZERO),
    .ALUOP          (ALUOP),
    .SUBMUXSEL      (SUBMUXSEL),
    .IMMUXSEL       (IMMUXSEL),
    .IMMEDIATE      (IMMEDIATE),
    .READREG1       (READREG1),
    .READREG2       (READREG2),
    .WRITEREG       (WRITEREG),
    .WRITEENABLE    (WRITEENABLE),
    .INSTR_DONE     (INSTR_DONE),
    .FAULT          (FAULT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at a falling edge with the sequencer in FETCH.
  task automatic run_instr(input logic [31:0] word, input int waits, input logic zero_v,
                           input logic [2:0] e_alu, input logic e_sub, input logic e_imm,
                           input logic e_we, input logic [31:0] e_pc);
    INSTR_IN       = word;
    INSTR_BUSYWAIT = (waits > 0);
    for (int i = 0; i < waits; i++) begin
      @(negedge CLK);
      chk("busy_read", 32'(INSTR_READ), 32'd1);
      if (i == waits - 1) INSTR_BUSYWAIT = 1'b0;
    end
    @(negedge CLK);
    chk("dec_read", 32'(INSTR_READ), 32'd0);
    INSTR_IN       = ~word;
    INSTR_BUSYWAIT = 1'b1;
    ZERO           = zero_v;
    @(negedge CLK);
    chk("ex_aluop", 32'(ALUOP), 32'(e_alu));
    chk("ex_sub", 32'(SUBMUXSEL), 32'(e_sub));
    chk("ex_imm", 32'(IMMUXSEL), 32'(e_imm));
    chk("ex_we", 32'(WRITEENABLE), 32'd0);
    @(negedge CLK);
    chk("wb_we", 32'(WRITEENABLE), 32'(e_we));
    chk("wb_done", 32'(INSTR_DONE), 32'd1);
    ZERO           = 1'b0;
    INSTR_BUSYWAIT = 1'b0;
    @(negedge CLK);
    chk("next_pc", INSTR_ADDR, e_pc);
    chk("post_we", 32'(WRITEENABLE), 32'd0);
    chk("post_done", 32'(INSTR_DONE), 32'd0);
    chk("post_read", 32'(INSTR_READ), 32'd1);
    chk("post_fault", 32'(FAULT), 32'd0);
  endtask

  initial begin
    RESET          = 1'b1;
    INSTR_IN       = 32'h0;
    INSTR_BUSYWAIT = 1'b0;
    ZERO           = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_pc", INSTR_ADDR, 32'h0);
    chk("rst_fault", 32'(FAULT), 32'd0);
    chk("rst_we", 32'(WRITEENABLE), 32'd0);
    chk("rst_done", 32'(INSTR_DONE), 32'd0);
    chk("rst_aluop", 32'(ALUOP), 32'd0);
    chk("rst_imm", 32'(IMMEDIATE), 32'd0);
    chk("rst_wr", 32'(WRITEREG), 32'd0);
    chk("rst_read", 32'(INSTR_READ), 32'd1);
    RESET = 1'b0;

    // add r3 = r1 + r2, zero wait
    run_instr(32'h02030102, 0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h04);
    chk("add_rr1", 32'(READREG1), 32'd1);
    chk("add_rr2", 32'(READREG2), 32'd2);
    chk("add_wr", 32'(WRITEREG), 32'd3);

    // loadi r5, #0xAB with four busy cycles
    run_instr(32'h000500AB, 4, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 32'h08);
    chk("ldi_imm", 32'(IMMEDIATE), 32'hAB);
    chk("ldi_wr", 32'(WRITEREG), 32'd5);

    // j +1 from 0x08 -> 0x10, then beq -2 taken -> 0x0C
    run_instr(32'h06010000, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h10);
    run_instr(32'h07FE0102, 0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 32'h0C);
    // j 0 from 0x0C -> 0x10, then beq -2 not taken -> 0x14
    run_instr(32'h06000000, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h10);
    run_instr(32'h07FE0102, 0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 32'h14);

    // sub with 14 busy cycles (one below timeout), and, or, mov with ZERO high
    run_instr(32'h03020104, 14, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 32'h18);
    run_instr(32'h04010203, 0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 32'h1C);
    run_instr(32'h05010203, 2, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 32'h20);
    run_instr(32'h01070600, 0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h24);

    // j -12 from 0x24 -> 0xFFFFFFF8, then j +3 wraps to 0x08
    run_instr(32'h06F40000, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8);
    run_instr(32'h06030000, 0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h08);

    // fetch timeout after 15 busy cycles
    INSTR_BUSYWAIT = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      chk("to_nofault", 32'(FAULT), 32'd0);
    end
    @(negedge CLK);
    chk("to_fault", 32'(FAULT), 32'd1);
    chk("to_read", 32'(INSTR_READ), 32'd0);
    INSTR_BUSYWAIT = 1'b0;
    INSTR_IN       = 32'h02030102;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("to_sticky", 32'(FAULT), 32'd1);
      chk("to_pc", INSTR_ADDR, 32'h08);
      chk("to_we", 32'(WRITEENABLE), 32'd0);
    end

    RESET = 1'b1;
    #1;
    chk("rst1_fault", 32'(FAULT), 32'd0);
    chk("rst1_pc", INSTR_ADDR, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // illegal opcode 0x2A after one good instruction
    run_instr(32'h02030102, 0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h04);
    INSTR_IN = 32'h2A000000;
    @(negedge CLK);
    chk("ill_dec_fault", 32'(FAULT), 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 22; i++) begin
      chk("ill_fault", 32'(FAULT), 32'd1);
      chk("ill_read", 32'(INSTR_READ), 32'd0);
      chk("ill_we", 32'(WRITEENABLE), 32'd0);
      chk("ill_pc", INSTR_ADDR, 32'h04);
      @(negedge CLK);
    end
    RESET = 1'b1;
    #1;
    chk("rst2_fault", 32'(FAULT), 32'd0);
    chk("rst2_pc", INSTR_ADDR, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;

    // reset asserted in the middle of a loadi writeback
    run_instr(32'h02030102, 0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h04);
    INSTR_IN = 32'h000100FF;
    repeat (3) @(negedge CLK);
    chk("wbrst_we_pre", 32'(WRITEENABLE), 32'd1);
    chk("wbrst_pc_pre", INSTR_ADDR, 32'h04);
    RESET = 1'b1;
    #1;
    chk("wbrst_we", 32'(WRITEENABLE), 32'd0);
    chk("wbrst_done", 32'(INSTR_DONE), 32'd0);
    chk("wbrst_pc", INSTR_ADDR, 32'h0);
    chk("wbrst_immux", 32'(IMMUXSEL), 32'd0);
    chk("wbrst_imm", 32'(IMMEDIATE), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    chk("wbrst_read", 32'(INSTR_READ), 32'd1);
    run_instr(32'h02030102, 0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b1, 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
